// File: rtl/fir_seq_pkg.sv
// Shared types and sizing for the FIR RAM sequencer: state encoding,
// coefficient geometry and RAM address layout.
package fir_seq_pkg;

  localparam int NUM_TAPS  = 10;
  localparam int NUM_BANKS = 4;
  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 6;
  localparam int TAP_W     = 4;
  localparam int BANK_W    = 2;

  // Output registers trail the state by one cycle, so counting to 2 here
  // leaves two idle bus cycles before the result pulse.
  localparam logic [TAP_W-1:0] DRAIN_LAST = TAP_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    READ   = 2'd2,
    DRAIN  = 2'd3
  } seqState_t;

endpackage

// File: rtl/fir_ram_sequencer_if.sv
// Coefficient valid/ready port plus the SpSram control and MAC enable bus
// that the sequencer drives toward the FIR datapath.
interface fir_ram_sequencer_if;
  import fir_seq_pkg::*;

  logic              iCoeffValid;
  logic [DATA_W-1:0] iCoeffData;
  logic              oCoeffReady;
  logic              oCsnRam;
  logic              oWrnRam;
  logic [ADDR_W-1:0] oAddrRam;
  logic [DATA_W-1:0] oWtDtRam;
  logic              oRdBroadcast;
  logic              oEnMul;
  logic              oEnAddAcc;

  modport master (
    input  iCoeffValid, iCoeffData,
    output oCoeffReady, oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
           oRdBroadcast, oEnMul, oEnAddAcc
  );

  modport slave (
    output iCoeffValid, iCoeffData,
    input  oCoeffReady, oCsnRam, oWrnRam, oAddrRam, oWtDtRam,
           oRdBroadcast, oEnMul, oEnAddAcc
  );

endinterface

// File: rtl/fir_tap_bank_counter.sv
// Tap counter with bank carry, shared by the coefficient load (tap+bank)
// and the read sweep (tap only) and reused as the drain timer.
module fir_tap_bank_counter
  import fir_seq_pkg::*;
(
  input  logic              iClk12M,
  input  logic              iRsn,
  input  logic              clear,
  input  logic              inc,
  output logic [TAP_W-1:0]  tap,
  output logic [BANK_W-1:0] bank,
  output logic              lastTap,
  output logic              lastBank
);

  assign lastTap  = (tap == TAP_W'(NUM_TAPS - 1));
  assign lastBank = (bank == BANK_W'(NUM_BANKS - 1));

  // Clear wins over increment; the tap wraps after the last tap and carries into the bank.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      tap  <= '0;
      bank <= '0;
    end else if (clear) begin
      tap  <= '0;
      bank <= '0;
    end else if (inc) begin
      if (lastTap) begin
        tap  <= '0;
        bank <= bank + 1'b1;
      end else begin
        tap <= tap + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_ram_sequencer.sv
// Generates coefficient-load writes and per-sample broadcast read sweeps for
// the FIR SpSram, with MAC enables aligned to the one-cycle RAM read latency.
module fir_ram_sequencer
  import fir_seq_pkg::*;
(
  input  logic                iClk12M,
  input  logic                iRsn,
  input  logic                iEnSample600k,
  input  logic                iCoeffUpdateFlag,
  fir_ram_sequencer_if.master bus,
  output logic                oOutValid,
  output logic                oUpdateDone,
  output logic                oSampleMiss,
  output logic                oBusy
);

  seqState_t         state, nextState;
  logic              flagPrev, flagRise;
  logic [TAP_W-1:0]  tap;
  logic [BANK_W-1:0] bank;
  logic              lastTap, lastBank;
  logic              cntClear, cntInc;

  logic              csnQ, wrnQ, rdQ, mulQ, accQ, readyQ;
  logic [ADDR_W-1:0] addrQ;
  logic [DATA_W-1:0] wtDtQ;

  logic              csnD, wrnD, rdD, readyD, doneD, outValidD, missD;
  logic [ADDR_W-1:0] addrD;
  logic [DATA_W-1:0] wtDtD;

  assign flagRise = iCoeffUpdateFlag && !flagPrev;

  fir_tap_bank_counter u_counter (
    .iClk12M  (iClk12M),
    .iRsn     (iRsn),
    .clear    (cntClear),
    .inc      (cntInc),
    .tap      (tap),
    .bank     (bank),
    .lastTap  (lastTap),
    .lastBank (lastBank)
  );

  // Next state and next values of every registered output.
  always_comb begin
    nextState = state;
    cntClear  = 1'b0;
    cntInc    = 1'b0;
    csnD      = 1'b1;
    wrnD      = 1'b1;
    addrD     = '0;
    wtDtD     = '0;
    rdD       = 1'b0;
    readyD    = 1'b0;
    doneD     = 1'b0;
    outValidD = 1'b0;
    missD     = iEnSample600k;

    case (state)
      IDLE: begin
        if (flagRise) begin
          nextState = UPDATE;
          readyD    = 1'b1;
        end else if (iEnSample600k) begin
          nextState = READ;
          missD     = 1'b0;
          csnD      = 1'b0;
          rdD       = 1'b1;
          addrD     = {2'b00, tap};
          cntInc    = 1'b1;
        end
      end
      UPDATE: begin
        if (!iCoeffUpdateFlag) begin
          nextState = IDLE;
          cntClear  = 1'b1;
        end else begin
          readyD = 1'b1;
          if (bus.iCoeffValid && readyQ) begin
            csnD  = 1'b0;
            wrnD  = 1'b0;
            addrD = {bank, tap};
            wtDtD = bus.iCoeffData;
            if (lastTap && lastBank) begin
              nextState = IDLE;
              cntClear  = 1'b1;
              doneD     = 1'b1;
              readyD    = 1'b0;
            end else begin
              cntInc = 1'b1;
            end
          end
        end
      end
      READ: begin
        csnD  = 1'b0;
        rdD   = 1'b1;
        addrD = {2'b00, tap};
        if (lastTap) begin
          nextState = DRAIN;
          cntClear  = 1'b1;
        end else begin
          cntInc = 1'b1;
        end
      end
      DRAIN: begin
        if (tap == DRAIN_LAST) begin
          nextState = IDLE;
          cntClear  = 1'b1;
          outValidD = 1'b1;
        end else begin
          cntInc = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // State and output registers; MAC enables are the read strobe delayed one and two cycles.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      state       <= IDLE;
      flagPrev    <= 1'b0;
      csnQ        <= 1'b1;
      wrnQ        <= 1'b1;
      addrQ       <= '0;
      wtDtQ       <= '0;
      rdQ         <= 1'b0;
      mulQ        <= 1'b0;
      accQ        <= 1'b0;
      readyQ      <= 1'b0;
      oOutValid   <= 1'b0;
      oUpdateDone <= 1'b0;
      oSampleMiss <= 1'b0;
      oBusy       <= 1'b0;
    end else begin
      state       <= nextState;
      flagPrev    <= iCoeffUpdateFlag;
      csnQ        <= csnD;
      wrnQ        <= wrnD;
      addrQ       <= addrD;
      wtDtQ       <= wtDtD;
      rdQ         <= rdD;
      mulQ        <= rdQ;
      accQ        <= mulQ;
      readyQ      <= readyD;
      oOutValid   <= outValidD;
      oUpdateDone <= doneD;
      oSampleMiss <= missD;
      oBusy       <= (state != IDLE);
    end
  end

  assign bus.oCoeffReady  = readyQ;
  assign bus.oCsnRam      = csnQ;
  assign bus.oWrnRam      = wrnQ;
  assign bus.oAddrRam     = addrQ;
  assign bus.oWtDtRam     = wtDtQ;
  assign bus.oRdBroadcast = rdQ;
  assign bus.oEnMul       = mulQ;
  assign bus.oEnAddAcc    = accQ;

endmodule

// File: tb/tb_fir_ram_sequencer.sv
// Self-checking bench for fir_ram_sequencer: directed scenarios plus a random
// phase, all compared against a cycle-timeline reference model.
module tb_fir_ram_sequencer;

  logic        clk;
  logic        rsn;
  logic        strobe;
  logic        flag;
  logic        outValid, updateDone, sampleMiss, busy;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  // Reference model: mode 0 idle, 1 sweeping, 2 loading coefficients.
  int          mode;
  int          sweepStart;
  int          wrCount;
  logic        prevFlag;
  bit          checkBusAll;

  logic        eCsn, eWrn, eRd, eMul, eAcc, eOV, eDone, eMiss, eBusy, eReady;
  logic [5:0]  eAddr;
  logic [15:0] eData;

  fir_ram_sequencer_if busIf();

  fir_ram_sequencer dut (
    .iClk12M          (clk),
    .iRsn             (rsn),
    .iEnSample600k    (strobe),
    .iCoeffUpdateFlag (flag),
    .bus              (busIf),
    .oOutValid        (outValid),
    .oUpdateDone      (updateDone),
    .oSampleMiss      (sampleMiss),
    .oBusy            (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic setDefaults();
    eCsn = 1'b1; eWrn = 1'b1; eRd = 1'b0; eMul = 1'b0; eAcc = 1'b0;
    eOV = 1'b0; eDone = 1'b0; eMiss = 1'b0; eBusy = 1'b0; eReady = 1'b0;
    eAddr = '0; eData = '0;
  endtask

  task automatic modelReset();
    mode        = 0;
    wrCount     = 0;
    prevFlag    = 1'b0;
    checkBusAll = 1'b1;
    setDefaults();
  endtask

  // One sampled clock edge, derived from the timing rules: tap k at start+k,
  // multiply at +1..+10, accumulate at +2..+11, result at +12, idle again at +13.
  task automatic modelStep();
    int d;
    logic rise;
    checkBusAll = 1'b0;
    setDefaults();
    if (mode == 1 && (cyc - sweepStart) >= 13) mode = 0;
    eBusy = (mode != 0);
    rise  = flag && !prevFlag;
    if (mode == 2) begin
      eMiss = strobe;
      if (!flag) begin
        mode = 0;
      end else begin
        eReady = 1'b1;
        if (busIf.iCoeffValid) begin
          eCsn  = 1'b0;
          eWrn  = 1'b0;
          eAddr = 6'((wrCount / 10) * 16 + (wrCount % 10));
          eData = busIf.iCoeffData;
          if (wrCount == 39) begin
            eDone  = 1'b1;
            eReady = 1'b0;
            mode   = 0;
          end
          wrCount++;
        end
      end
    end else if (mode == 1) begin
      eMiss = strobe;
    end else if (rise) begin
      mode    = 2;
      wrCount = 0;
      eReady  = 1'b1;
      eMiss   = strobe;
    end else if (strobe) begin
      mode       = 1;
      sweepStart = cyc;
    end
    if (mode == 1) begin
      d = cyc - sweepStart;
      if (d <= 9) begin
        eCsn  = 1'b0;
        eRd   = 1'b1;
        eAddr = 6'(d);
      end
      eMul = (d >= 1 && d <= 10);
      eAcc = (d >= 2 && d <= 11);
      eOV  = (d == 12);
    end
    prevFlag = flag;
  endtask

  task automatic compareAll();
    checkOutput("csn", busIf.oCsnRam, eCsn);
    checkOutput("wrn", busIf.oWrnRam, eWrn);
    checkOutput("rdBroadcast", busIf.oRdBroadcast, eRd);
    checkOutput("enMul", busIf.oEnMul, eMul);
    checkOutput("enAddAcc", busIf.oEnAddAcc, eAcc);
    checkOutput("outValid", outValid, eOV);
    checkOutput("updateDone", updateDone, eDone);
    checkOutput("sampleMiss", sampleMiss, eMiss);
    checkOutput("busy", busy, eBusy);
    checkOutput("coeffReady", busIf.oCoeffReady, eReady);
    if (checkBusAll || !eCsn) checkOutput("addr", busIf.oAddrRam, eAddr);
    if (checkBusAll || !eWrn) checkOutput("wtData", busIf.oWtDtRam, eData);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!rsn) modelReset();
    else modelStep();
    compareAll();
  endtask

  task automatic applyStimulus(input bit s, input bit f, input bit v, input logic [15:0] d);
    strobe             = s;
    flag               = f;
    busIf.iCoeffValid  = v;
    busIf.iCoeffData   = d;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, flag, 1'b0, 16'h0);
  endtask

  initial begin
    bit fl;
    clk               = 1'b0;
    rsn               = 1'b1;
    strobe            = 1'b0;
    flag              = 1'b0;
    busIf.iCoeffValid = 1'b0;
    busIf.iCoeffData  = '0;

    // Reset values.
    #2 rsn = 1'b0;
    #1 modelReset();
    compareAll();
    tick();
    tick();
    rsn = 1'b1;
    idle(3);

    // Single sweep from idle.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    idle(18);

    // Back-to-back load of 0x0001..0x0028, flag held afterwards.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    for (int w = 0; w < 40; w++) applyStimulus(1'b0, 1'b1, 1'b1, 16'(w + 1));
    idle(5);
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    idle(16);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

    // Load with valid toggling every other cycle.
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    for (int w = 0; w < 80; w++) applyStimulus(1'b0, 1'b1, w[0] == 1'b0, 16'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);
    idle(3);

    // Strobe mid-sweep is dropped; the one at +20 starts a new sweep.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    idle(4);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    idle(14);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    idle(19);

    // Strobe together with an update edge: update wins, strobe dropped.
    applyStimulus(1'b1, 1'b1, 1'b0, 16'h0);
    // Abort after 17 writes, then a fresh load restarting at address 0.
    for (int w = 0; w < 17; w++) applyStimulus(1'b0, 1'b1, 1'b1, 16'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b1, 16'h0);
    idle(3);
    applyStimulus(1'b0, 1'b1, 1'b0, 16'h0);
    for (int w = 0; w < 60; w++) applyStimulus(1'b0, 1'b1, $urandom_range(0, 3) != 0, 16'($urandom));
    idle(2);
    applyStimulus(1'b0, 1'b0, 1'b0, 16'h0);

    // Asynchronous reset while tap 4 is on the bus.
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    idle(4);
    #2 rsn = 1'b0;
    #1 modelReset();
    compareAll();
    idle(2);
    rsn = 1'b1;
    idle(20);
    applyStimulus(1'b1, 1'b0, 1'b0, 16'h0);
    idle(19);

    // Random traffic: nominal 20-cycle strobes with jitter, random update requests.
    fl = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      bit s;
      s = (i % 20 == 0) || ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 69) == 0) fl = !fl;
      applyStimulus(s, fl, $urandom_range(0, 3) != 0, 16'($urandom));
    end
    idle(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_ram_sequencer.md
# fir_ram_sequencer

Master-side sequencer that generates the SpSram control and MAC enable stream that the FIR control FSM consumes: `iCsnRam`, `iWrnRam`, `iAddrRam`, `iWtDtRam`, `iEnMul` and `iEnAddAcc`. It loads 40 coefficients (4 banks × 10 taps) through a valid/ready port on a coefficient-update request. On every 600 kHz sample strobe it issues a 10-tap broadcast read sweep with aligned multiply and accumulate enables. It sits between the host/coefficient source and the FIR FSM, replacing testbench-driven RAM traffic.

## Interface
- NUM_TAPS, 10, taps per bank (address bits [3:0], 0..NUM_TAPS-1)
- NUM_BANKS, 4, coefficient banks (address bits [5:4])
- DATA_W, 16, coefficient width
- iClk12M  in  1  12 MHz system clock; single clock domain
- iRsn  in  1  reset; asynchronous, active-low
- iEnSample600k  in  1  one-cycle sample strobe, nominally every 20 clocks
- iCoeffUpdateFlag  in  1  level request; its rising edge starts a coefficient load
- iCoeffValid  in  1  coefficient word valid
- iCoeffData  in  DATA_W  coefficient word
- oCoeffReady  out  1  sequencer accepts a coefficient this cycle
- oCsnRam  out  1  RAM chip select, active-low
- oWrnRam  out  1  RAM write strobe, active-low
- oAddrRam  out  6  {bank[1:0], tap[3:0]}
- oWtDtRam  out  DATA_W  write data
- oRdBroadcast  out  1  read sweep: all four banks are enabled at oAddrRam[3:0]
- oEnMul  out  1  multiplier enable
- oEnAddAcc  out  1  accumulator enable
- oOutValid  out  1  one-cycle pulse when the sample result is complete
- oUpdateDone  out  1  one-cycle pulse after the 40th coefficient write
- oSampleMiss  out  1  one-cycle pulse when a strobe is dropped
- oBusy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE: accept requests.
  - UPDATE: load coefficients.
  - READ: issue the 10-tap read sweep.
  - DRAIN: flush the MAC pipeline.
- Every output is registered.
- Reset value of all outputs:
  - oCsnRam=1, oWrnRam=1.
  - oAddrRam=0, oWtDtRam=0.
  - All enables and pulses 0; state IDLE; tap/bank counters 0.
- IDLE → UPDATE: rising edge of iCoeffUpdateFlag. This has priority over a same-cycle strobe, which is dropped with oSampleMiss.
- IDLE → READ: iEnSample600k=1.
- UPDATE:
  - oCoeffReady=1.
  - Each cycle with iCoeffValid&&oCoeffReady produces one write: oCsnRam=0, oWrnRam=0, oAddrRam={bank,tap}, oWtDtRam=iCoeffData.
  - Tap increments 0..9, then wraps to 0 and bank increments.
  - Cycles without valid: oCsnRam=1.
  - After write {3,9}: oUpdateDone pulse, → IDLE, counters cleared.
- UPDATE abort: iCoeffUpdateFlag falling before the 40th write → IDLE, counters cleared, no oUpdateDone. Partially written RAM contents are left as they are.
- READ:
  - oCsnRam=0, oWrnRam=1, oRdBroadcast=1.
  - oAddrRam={2'b00,tap}, tap 0..9.
  - At tap 9 → DRAIN.
- DRAIN: 2 cycles, oCsnRam=1; then oOutValid pulse and → IDLE.
- A strobe in any non-IDLE state is dropped and pulses oSampleMiss. Strobes during UPDATE are dropped in the same way.
- Held iCoeffUpdateFlag after completion does not retrigger; a new rising edge is required.

## Timing
- Strobe sampled at edge N:
  - Read tap k presented at cycles N+1+k, k=0..9.
  - oEnMul high N+2..N+11 (1-cycle RAM read latency).
  - oEnAddAcc high N+3..N+12.
  - oOutValid pulses at N+13; oBusy low from N+14.
- Sweep length is 13 cycles, which is less than the 20-cycle sample period. The next strobe at N+20 is accepted.
- Update rising edge sampled at edge N: oCoeffReady high from N+1. Write data/address appear on the edge after the accepting handshake.
- Asynchronous reset mid-sweep or mid-update: outputs return to reset values immediately. No oOutValid or oUpdateDone is produced.

## Structure
- Shared package `fir_seq_pkg`:
  - State enum (2 bits: IDLE, UPDATE, READ, DRAIN).
  - NUM_TAPS, NUM_BANKS, DATA_W.
  - RAM address width 6.
- Sub-module `fir_tap_bank_counter`:
  - Tap counter 0..NUM_TAPS-1 with wrap and bank carry.
  - Clear and increment inputs; last-tap and last-bank flags.
  - Reused by the UPDATE and READ states.

## Test plan
- Reset, then a strobe: addresses 0..9 in cycles N+1..N+10 with CsN=0/WrN=1; oEnMul N+2..N+11; oEnAddAcc N+3..N+12; oOutValid at N+13.
- Update edge, then 40 back-to-back valid words 0x0001..0x0028: writes to addr 0x00..0x09, 0x10..0x19, 0x20..0x29, 0x30..0x39 with matching data; oUpdateDone pulse after the last write.
- Update with iCoeffValid toggling every other cycle: no write cycles when valid=0; all 40 writes land in order.
- Strobe at N+5 during a read sweep: oSampleMiss pulse, sweep timing unchanged; the strobe at N+20 starts a new sweep.
- Flag falls after 17 writes: → IDLE, no oUpdateDone; the next rising edge restarts at addr 0x00.
- iRsn asserted at tap 4 of a sweep: oCsnRam=1 and all enables 0 immediately; no oOutValid; normal sweep after release.
